// File: rtl/data_sram_responder.sv
// SRAM-like data-side responder: word-addressed memory behind an in-order
// queue of outstanding requests. Optional random latency/backpressure: DSRAM_RAND_DELAY_EN.
module data_sram_responder #(
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CNT_W    = PTR_W + 1;
  localparam logic [3:0]      BASE_CNT = 4'(LATENCY - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]       mem [0:(1 << ADDR_W) - 1];

  logic [DEPTH-1:0]  q_valid;
  logic [DEPTH-1:0]  q_wr;
  logic [31:0]       q_rdata [DEPTH];
  logic [3:0]        q_cnt   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [ADDR_W-1:0] idx;
  logic              full;
  logic              accept_ok;
  logic              push;
  logic              pop;
  logic [3:0]        load_cnt;

  // Size and sub-word/upper address bits carry no meaning for this memory.
  logic unused_bits;
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  assign idx  = data_sram_addr[ADDR_W+1:2];
  assign full = (count == FULL_CNT);

`ifdef DSRAM_RAND_DELAY_EN
  logic [15:0] lfsr;
  logic [4:0]  rand_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign rand_sum  = 5'(BASE_CNT) + 5'(lfsr[2:0]);
  assign load_cnt  = (rand_sum > 5'd15) ? 4'd15 : rand_sum[3:0];
  assign accept_ok = !full && !reset && (lfsr[5:3] != 3'b000);
`else
  assign load_cnt  = BASE_CNT;
  assign accept_ok = !full && !reset;
`endif

  assign data_sram_addr_ok = accept_ok;
  assign push = data_sram_req && accept_ok;
  assign pop  = (count != '0) && (q_cnt[rd_ptr] == 4'd0);

  // NOTE: memory arrays carry no reset so they map onto plain RAM; contents
  // survive reset by design.
  always_ff @(posedge clk) begin
    if (push && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so the read capture
  // below sees mem[idx] as it was before a write on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      q_valid <= '0;
      q_wr    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_rdata[i] <= '0;
        q_cnt[i]   <= '0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == PTR_W'(i))) begin
          q_valid[i] <= 1'b1;
          q_wr[i]    <= data_sram_wr;
          q_rdata[i] <= mem[idx];
          q_cnt[i]   <= load_cnt;
        end else begin
          if (pop && (rd_ptr == PTR_W'(i))) q_valid[i] <= 1'b0;
          // Every waiting entry ages, whatever its queue position.
          if (q_valid[i] && (q_cnt[i] != 4'd0)) q_cnt[i] <= q_cnt[i] - 4'd1;
        end
      end
    end
  end

  // NOTE: outputs get defaults first so no path through the block infers a latch.
  always_comb begin
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    if (pop) begin
      data_sram_data_ok = 1'b1;
      if (!q_wr[rd_ptr]) data_sram_rdata = q_rdata[rd_ptr];
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: a LATENCY=2 instance driven from a vector
// table and a LATENCY=8 instance for queue-full and mid-flight reset sequences.
module tb_data_sram_responder;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;
  localparam int LAT_A  = 2;
  localparam int LAT_B  = 8;

  typedef struct {
    logic [31:0] rdata;
    int          due;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_acc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  size_s = 2'd2;
  logic        req_s   [2];
  logic        wr_s    [2];
  logic [3:0]  wstrb_s [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] exp_rd  [2];
  logic        aok_s   [2];
  logic        dok_s   [2];
  logic [31:0] rdata_s [2];

  exp_t sb_q [2][$];
  int   occ [2];
  logic acc [2];
  int   dok_cnt [2];
  int   stall_b;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  vec_t vecs [12];

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .reset(reset),
    .data_sram_req(req_s[0]), .data_sram_wr(wr_s[0]), .data_sram_size(size_s),
    .data_sram_wstrb(wstrb_s[0]), .data_sram_addr(addr_s[0]), .data_sram_wdata(wdata_s[0]),
    .data_sram_addr_ok(aok_s[0]), .data_sram_data_ok(dok_s[0]), .data_sram_rdata(rdata_s[0])
  );

  data_sram_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .reset(reset),
    .data_sram_req(req_s[1]), .data_sram_wr(wr_s[1]), .data_sram_size(size_s),
    .data_sram_wstrb(wstrb_s[1]), .data_sram_addr(addr_s[1]), .data_sram_wdata(wdata_s[1]),
    .data_sram_addr_ok(aok_s[1]), .data_sram_data_ok(dok_s[1]), .data_sram_rdata(rdata_s[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  // One clock: sample/score both DUTs mid-cycle, then step past the edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      acc[k] = 1'b0;
      if (reset) begin
        check("rst_addr_ok", 32'(aok_s[k]), 32'd0);
        check("rst_data_ok", 32'(dok_s[k]), 32'd0);
        check("rst_rdata",   rdata_s[k],    32'd0);
      end else begin
        check("addr_ok", 32'(aok_s[k]), 32'(occ[k] < DEPTH));
        if (dok_s[k]) begin
          dok_cnt[k]++;
          if (sb_q[k].size() == 0) begin
            check("spurious_data_ok", 32'(dok_s[k]), 32'd0);
          end else begin
            e = sb_q[k].pop_front();
            occ[k]--;
            check("data_ok_cycle", 32'(cyc), 32'(e.due));
            check("rdata", rdata_s[k], e.rdata);
          end
        end else begin
          check("rdata_idle", rdata_s[k], 32'd0);
          if (sb_q[k].size() != 0 && sb_q[k][0].due <= cyc) begin
            check("data_ok_missing", 32'(dok_s[k]), 32'd1);
            e = sb_q[k].pop_front();
            occ[k]--;
          end
        end
        if (req_s[k] && aok_s[k]) begin
          acc[k]  = 1'b1;
          e.rdata = wr_s[k] ? 32'd0 : exp_rd[k];
          e.due   = cyc + lat_of(k);
          sb_q[k].push_back(e);
          occ[k]++;
        end
        if (k == 1 && req_s[k] && !aok_s[k]) stall_b++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input int k, input logic wr, input logic [3:0] strb,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp);
    req_s[k]   = 1'b1;
    wr_s[k]    = wr;
    wstrb_s[k] = strb;
    addr_s[k]  = addr;
    wdata_s[k] = wdata;
    exp_rd[k]  = exp;
  endtask

  task automatic idle(input int k);
    req_s[k]   = 1'b0;
    wr_s[k]    = 1'b0;
    wstrb_s[k] = 4'h0;
  endtask

  task automatic issue(input int k);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!acc[k] && n < 50);
    check("issue_accepted", 32'(acc[k]), 32'd1);
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (occ[k] != 0 && n < 60) begin
      tick();
      n++;
    end
    check("drain_done", 32'(occ[k]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;

    vecs[0]  = '{1'b1, 4'hF,    32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b1};
    vecs[1]  = '{1'b0, 4'h0,    32'h0000_0010, 32'h0,         32'hDEAD_BEEF,  1'b1};
    vecs[2]  = '{1'b1, 4'b0100, 32'h0000_0010, 32'h00AA_0000, 32'h0,          1'b1};
    vecs[3]  = '{1'b0, 4'h0,    32'h0000_0010, 32'h0,         32'hDEAA_BEEF,  1'b1};
    vecs[4]  = '{1'b1, 4'hF,    32'h0000_4010, 32'h1234_5678, 32'h0,          1'b1};
    vecs[5]  = '{1'b0, 4'h0,    32'h0000_0010, 32'h0,         32'h1234_5678,  1'b1};
    vecs[6]  = '{1'b0, 4'h0,    32'h0000_4013, 32'h0,         32'h1234_5678,  1'b1};
    vecs[7]  = '{1'b1, 4'hF,    32'h0000_0020, 32'hCAFE_F00D, 32'h0,          1'b1};
    vecs[8]  = '{1'b1, 4'h0,    32'h0000_0020, 32'hFFFF_FFFF, 32'h0,          1'b1};
    vecs[9]  = '{1'b0, 4'h0,    32'h0000_0020, 32'h0,         32'hCAFE_F00D,  1'b1};
    vecs[10] = '{1'b1, 4'b0011, 32'h0000_0022, 32'h0000_5555, 32'h0,          1'b1};
    vecs[11] = '{1'b0, 4'h0,    32'h0000_0020, 32'h0,         32'hCAFE_5555,  1'b1};

    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    stall_b = 0;
    for (int k = 0; k < 2; k++) begin
      occ[k]     = 0;
      dok_cnt[k] = 0;
      acc[k]     = 1'b0;
      addr_s[k]  = '0;
      wdata_s[k] = '0;
      exp_rd[k]  = '0;
      idle(k);
    end
    reset = 1'b1;

    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset: ready, no responses, zero read data.
    repeat (20) tick();

    // Table-driven single-beat traffic on the LATENCY=2 instance.
    for (int i = 0; i < 12; i++) begin
      drive(0, vecs[i].wr, vecs[i].wstrb, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
      tick();
      check("vec_accept", 32'(acc[0]), 32'(vecs[i].exp_acc));
    end
    idle(0);
    drain(0);

    // Preload six words in the LATENCY=8 instance.
    for (int i = 0; i < 6; i++) begin
      drive(1, 1'b1, 4'hF, 32'(4 * i), 32'hA500_0000 + 32'(i), 32'h0);
      issue(1);
    end
    idle(1);
    drain(1);

    // Six back-to-back reads against a 4-deep queue: 5 stalled cycles expected.
    stall_b = 0;
    base    = dok_cnt[1];
    for (int i = 0; i < 6; i++) begin
      drive(1, 1'b0, 4'h0, 32'(4 * i), 32'h0, 32'hA500_0000 + 32'(i));
      issue(1);
    end
    idle(1);
    drain(1);
    check("full_stall_cycles", 32'(stall_b), 32'd5);
    check("full_pulse_count", 32'(dok_cnt[1] - base), 32'd6);

    // Reset with three reads in flight: nothing stale may come back.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b0, 4'h0, 32'(4 * i), 32'h0, 32'hA500_0000 + 32'(i));
      issue(1);
    end
    idle(1);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_data_ok", 32'(dok_s[1]), 32'd0);
    check("async_rst_addr_ok", 32'(aok_s[1]), 32'd0);
    check("async_rst_rdata",   rdata_s[1],    32'd0);
    for (int k = 0; k < 2; k++) begin
      sb_q[k].delete();
      occ[k] = 0;
    end
    tick();
    tick();
    reset = 1'b0;
    repeat (12) tick();

    // Memory survives reset; the instance still works afterwards.
    drive(1, 1'b0, 4'h0, 32'h0000_0008, 32'h0, 32'hA500_0002);
    issue(1);
    drive(1, 1'b1, 4'hF, 32'h0000_0030, 32'h0BAD_F00D, 32'h0);
    issue(1);
    drive(1, 1'b0, 4'h0, 32'h0000_0030, 32'h0, 32'h0BAD_F00D);
    issue(1);
    idle(1);
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
